// File: rtl/spi_slave_cfg.sv
// SPI slave with configurable word width, CPOL/CPHA and bit order. Pins are synchronised
// into clk; TX is double-buffered behind a valid/ready shadow register.
module spi_slave_cfg #(
   parameter int WIDTH     = 16,
   parameter int CPOL      = 0,
   parameter int CPHA      = 0,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs_bar,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             tx_done,
   output logic             tx_underrun,
   output logic             frame_abort
);
   localparam int             CW        = $clog2(WIDTH) + 1;
   localparam logic           SCLK_IDLE = 1'(CPOL);
   localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

   typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

   logic [2:0]       sclk_sync_r, cs_sync_r;
   logic [1:0]       mosi_sync_r;
   state_t           state_r, state_nxt_s;
   logic [CW-1:0]    bit_cnt_r, bit_cnt_nxt_s;
   logic [WIDTH-1:0] tx_sr_r, tx_sr_nxt_s, rx_sr_r, rx_sr_nxt_s;
   logic [WIDTH-1:0] shadow_r, shadow_nxt_s, rx_data_r, rx_data_nxt_s;
   logic             tx_ready_r, tx_ready_nxt_s, hold_r, hold_nxt_s;
   logic             miso_r, miso_nxt_s, miso_oe_r, oe_nxt_s;
   logic             rx_valid_r, rx_valid_nxt_s, tx_done_r, tx_done_nxt_s;
   logic             underrun_r, underrun_nxt_s, abort_r, abort_nxt_s;
   logic             load_s, sclk_chg_s, lead_s, trail_s, sample_evt_s, shift_evt_s;
   logic             cs_fall_s, cs_rise_s;

   assign sclk_chg_s   = sclk_sync_r[1] ^ sclk_sync_r[2];
   assign lead_s       = sclk_chg_s & (sclk_sync_r[1] != SCLK_IDLE);
   assign trail_s      = sclk_chg_s & (sclk_sync_r[1] == SCLK_IDLE);
   assign sample_evt_s = (CPHA == 0) ? lead_s : trail_s;
   assign shift_evt_s  = (CPHA == 0) ? trail_s : lead_s;
   assign cs_fall_s    = cs_sync_r[2] & ~cs_sync_r[1];
   assign cs_rise_s    = ~cs_sync_r[2] & cs_sync_r[1];

   // Two-flop pin synchronisers plus a third stage for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_r <= {3{SCLK_IDLE}};
         cs_sync_r   <= 3'b111;
         mosi_sync_r <= 2'b00;
      end else begin
         sclk_sync_r <= {sclk_sync_r[1:0], sclk};
         cs_sync_r   <= {cs_sync_r[1:0], cs_bar};
         mosi_sync_r <= {mosi_sync_r[0], mosi};
      end
   end

   // Frame FSM, shift registers, shadow handshake and flag pulses
   always_comb begin
      state_nxt_s    = state_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      tx_sr_nxt_s    = tx_sr_r;
      rx_sr_nxt_s    = rx_sr_r;
      rx_data_nxt_s  = rx_data_r;
      shadow_nxt_s   = shadow_r;
      tx_ready_nxt_s = tx_ready_r;
      hold_nxt_s     = hold_r;
      oe_nxt_s       = miso_oe_r;
      rx_valid_nxt_s = 1'b0;
      tx_done_nxt_s  = 1'b0;
      underrun_nxt_s = 1'b0;
      abort_nxt_s    = 1'b0;
      load_s         = 1'b0;
      miso_nxt_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cs_fall_s) begin
               state_nxt_s   = ST_ACTIVE;
               oe_nxt_s      = 1'b1;
               bit_cnt_nxt_s = CNT_ZERO;
               rx_sr_nxt_s   = WORD_ZERO;
               hold_nxt_s    = (CPHA != 0);
               load_s        = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise_s) begin
               state_nxt_s   = ST_IDLE;
               oe_nxt_s      = 1'b0;
               abort_nxt_s   = (bit_cnt_r != CNT_ZERO);
               bit_cnt_nxt_s = CNT_ZERO;
               rx_sr_nxt_s   = WORD_ZERO;
            end else if (sample_evt_s) begin
               if (MSB_FIRST != 0) begin
                  rx_sr_nxt_s = {rx_sr_r[WIDTH-2:0], mosi_sync_r[1]};
               end else begin
                  rx_sr_nxt_s = {mosi_sync_r[1], rx_sr_r[WIDTH-1:1]};
               end
               if (bit_cnt_r == LAST_BIT) begin
                  bit_cnt_nxt_s  = CNT_ZERO;
                  rx_data_nxt_s  = rx_sr_nxt_s;
                  rx_valid_nxt_s = 1'b1;
                  tx_done_nxt_s  = (CPHA != 0);
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
               end
            end else if (shift_evt_s) begin
               // bit_cnt==0 on a shift edge means a word boundary
               if (bit_cnt_r != CNT_ZERO) begin
                  if (MSB_FIRST != 0) begin
                     tx_sr_nxt_s = {tx_sr_r[WIDTH-2:0], 1'b0};
                  end else begin
                     tx_sr_nxt_s = {1'b0, tx_sr_r[WIDTH-1:1]};
                  end
               end else if (hold_r) begin
                  hold_nxt_s = 1'b0;
               end else begin
                  load_s        = 1'b1;
                  tx_done_nxt_s = (CPHA == 0);
               end
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
      if (load_s) begin
         if (!tx_ready_r) begin
            tx_sr_nxt_s    = shadow_r;
            tx_ready_nxt_s = 1'b1;
         end else begin
            tx_sr_nxt_s    = WORD_ZERO;
            underrun_nxt_s = 1'b1;
         end
      end else begin
         underrun_nxt_s = 1'b0;
      end
      if (tx_valid && tx_ready_r) begin
         shadow_nxt_s   = tx_data;
         tx_ready_nxt_s = 1'b0;
      end else begin
         shadow_nxt_s = shadow_r;
      end
      // With CPHA=1 the first bit is withheld until the first leading edge
      if (oe_nxt_s && !hold_nxt_s) begin
         miso_nxt_s = (MSB_FIRST != 0) ? tx_sr_nxt_s[WIDTH-1] : tx_sr_nxt_s[0];
      end else begin
         miso_nxt_s = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         bit_cnt_r  <= CNT_ZERO;
         tx_sr_r    <= WORD_ZERO;
         rx_sr_r    <= WORD_ZERO;
         rx_data_r  <= WORD_ZERO;
         shadow_r   <= WORD_ZERO;
         tx_ready_r <= 1'b1;
         hold_r     <= 1'b0;
         miso_r     <= 1'b0;
         miso_oe_r  <= 1'b0;
         rx_valid_r <= 1'b0;
         tx_done_r  <= 1'b0;
         underrun_r <= 1'b0;
         abort_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         tx_sr_r    <= tx_sr_nxt_s;
         rx_sr_r    <= rx_sr_nxt_s;
         rx_data_r  <= rx_data_nxt_s;
         shadow_r   <= shadow_nxt_s;
         tx_ready_r <= tx_ready_nxt_s;
         hold_r     <= hold_nxt_s;
         miso_r     <= miso_nxt_s;
         miso_oe_r  <= oe_nxt_s;
         rx_valid_r <= rx_valid_nxt_s;
         tx_done_r  <= tx_done_nxt_s;
         underrun_r <= underrun_nxt_s;
         abort_r    <= abort_nxt_s;
      end
   end

   assign miso        = miso_r;
   assign miso_oe     = miso_oe_r;
   assign tx_ready    = tx_ready_r;
   assign rx_data     = rx_data_r;
   assign rx_valid    = rx_valid_r;
   assign tx_done     = tx_done_r;
   assign tx_underrun = underrun_r;
   assign frame_abort = abort_r;
endmodule

// File: tb/tb_spi_slave_cfg.sv
// Bench for spi_slave_cfg: five instances (modes 0-3 at 16 bits, mode 0 LSB-first at 8 bits)
// driven by an SPI master model and checked against a word-level model of loads and pulses.
module tb_spi_slave_cfg;
   localparam int NDUT = 5;

   logic clk = 1'b0;
   logic reset;
   logic sclk_a [NDUT], cs_a [NDUT], mosi_a [NDUT], miso_a [NDUT], oe_a [NDUT];
   logic tx_valid_a [NDUT], tx_ready_a [NDUT], rx_valid_a [NDUT];
   logic tx_done_a [NDUT], und_a [NDUT], abort_a [NDUT];
   logic [15:0] tx_data_a [NDUT], rx_data_a [NDUT], exp_rx [NDUT];
   int rx_cnt [NDUT], done_cnt [NDUT], und_cnt [NDUT], abort_cnt [NDUT];
   logic [15:0] rx_log [NDUT][32];
   logic [15:0] m_tx [4], m_rx [4], f_tx [4];
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = (g == 4) ? 8 : 16;
      logic [W-1:0] rx_d;
      spi_slave_cfg #(
         .WIDTH(W), .CPOL((g == 2 || g == 3) ? 1 : 0),
         .CPHA((g == 1 || g == 3) ? 1 : 0), .MSB_FIRST((g == 4) ? 0 : 1)
      ) u_dut (
         .clk(clk), .reset(reset), .sclk(sclk_a[g]), .cs_bar(cs_a[g]), .mosi(mosi_a[g]),
         .miso(miso_a[g]), .miso_oe(oe_a[g]), .tx_data(tx_data_a[g][W-1:0]),
         .tx_valid(tx_valid_a[g]), .tx_ready(tx_ready_a[g]), .rx_data(rx_d),
         .rx_valid(rx_valid_a[g]), .tx_done(tx_done_a[g]), .tx_underrun(und_a[g]),
         .frame_abort(abort_a[g])
      );
      assign rx_data_a[g] = 16'(rx_d);
   end

   function automatic int w_of(input int s);      return (s == 4) ? 8 : 16; endfunction
   function automatic logic cpol_of(input int s); return (s == 2 || s == 3); endfunction
   function automatic logic cpha_of(input int s); return (s == 1 || s == 3); endfunction
   function automatic logic msb_of(input int s);  return (s != 4);           endfunction
   function automatic logic [15:0] mask_of(input int s);
      return (s == 4) ? 16'h00FF : 16'hFFFF;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // pulse counters and received-word log, sampled mid-cycle
   always @(negedge clk) begin
      for (int g = 0; g < NDUT; g++) begin
         if (rx_valid_a[g] === 1'b1) begin
            rx_log[g][rx_cnt[g] % 32] = rx_data_a[g];
            rx_cnt[g]++;
         end
         if (tx_done_a[g] === 1'b1) done_cnt[g]++;
         if (und_a[g] === 1'b1)     und_cnt[g]++;
         if (abort_a[g] === 1'b1)   abort_cnt[g]++;
      end
   end

   task automatic half_period();
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic master(input int s, input int nfull, input int part);
      int w, nb, idx;
      logic cp;
      logic [15:0] cap;
      w  = w_of(s);
      cp = cpol_of(s);
      repeat (10) @(posedge clk);
      #1;
      cs_a[s] = 1'b0;
      half_period();
      check_val("miso_oe_active", 32'(oe_a[s]), 32'd1);
      for (int k = 0; k < nfull + ((part > 0) ? 1 : 0); k++) begin
         nb  = (k < nfull) ? w : part;
         cap = 16'h0000;
         for (int b = 0; b < nb; b++) begin
            idx = msb_of(s) ? (w - 1 - b) : b;
            if (!cpha_of(s)) begin
               mosi_a[s] = m_tx[k][idx];
               half_period();
               cap[idx]  = miso_a[s];
               sclk_a[s] = ~cp;
               half_period();
               sclk_a[s] = cp;
            end else begin
               sclk_a[s] = ~cp;
               mosi_a[s] = m_tx[k][idx];
               half_period();
               cap[idx]  = miso_a[s];
               sclk_a[s] = cp;
               half_period();
            end
         end
         m_rx[k] = cap;
      end
      half_period();
      cs_a[s]   = 1'b1;
      mosi_a[s] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic feeder(input int s, input int n);
      int t;
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (tx_ready_a[s] !== 1'b1 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
         end
         check_val("feed_ready", 32'(tx_ready_a[s]), 32'd1);
         tx_data_a[s]  = f_tx[i];
         tx_valid_a[s] = 1'b1;
         @(posedge clk);
         #1;
         tx_valid_a[s] = 1'b0;
      end
   endtask

   task automatic random_words(input int s);
      for (int k = 0; k < 4; k++) begin
         m_tx[k] = 16'($urandom) & mask_of(s);
         f_tx[k] = 16'($urandom) & mask_of(s);
      end
   endtask

   // Model: each word start pops one shadow word or underruns; CPHA=0 also loads after the last word
   task automatic run_frame(input int s, input int nfull, input int part, input int shortfall);
      int nwords, nload, nfeed, rx0, d0, u0, a0;
      logic [15:0] loaded;
      nwords = nfull + ((part > 0) ? 1 : 0);
      nload  = cpha_of(s) ? ((nwords > 0) ? nwords : 1) : nfull + 1;
      nfeed  = (shortfall >= nload) ? 0 : nload - shortfall;
      rx0 = rx_cnt[s]; d0 = done_cnt[s]; u0 = und_cnt[s]; a0 = abort_cnt[s];
      fork
         master(s, nfull, part);
         feeder(s, nfeed);
      join
      check_val("rx_valid_count", 32'(rx_cnt[s] - rx0), 32'(nfull));
      for (int k = 0; k < nfull; k++) begin
         loaded = (k < nfeed) ? f_tx[k] : 16'h0000;
         check_val("rx_word", 32'(rx_log[s][(rx0 + k) % 32]), 32'(m_tx[k] & mask_of(s)));
         check_val("miso_word", 32'(m_rx[k]), 32'(loaded));
      end
      if (nfull > 0) exp_rx[s] = m_tx[nfull-1] & mask_of(s);
      check_val("rx_data_hold", 32'(rx_data_a[s]), 32'(exp_rx[s]));
      check_val("tx_done_count", 32'(done_cnt[s] - d0), 32'(nfull));
      check_val("underrun_count", 32'(und_cnt[s] - u0), 32'(nload - nfeed));
      check_val("abort_count", 32'(abort_cnt[s] - a0), (part > 0) ? 32'd1 : 32'd0);
      check_val("tx_ready_idle", 32'(tx_ready_a[s]), 32'd1);
      check_val("miso_oe_idle", 32'(oe_a[s]), 32'd0);
      check_val("miso_idle", 32'(miso_a[s]), 32'd0);
   endtask

   task automatic check_reset_outs(input int g);
      check_val("rst_miso", 32'(miso_a[g]), 32'd0);
      check_val("rst_miso_oe", 32'(oe_a[g]), 32'd0);
      check_val("rst_tx_ready", 32'(tx_ready_a[g]), 32'd1);
      check_val("rst_rx_data", 32'(rx_data_a[g]), 32'd0);
      check_val("rst_pulses", {28'd0, rx_valid_a[g], tx_done_a[g], und_a[g], abort_a[g]}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, w, nfull, part, a0;
      reset = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
         sclk_a[g] = cpol_of(g); cs_a[g] = 1'b1; mosi_a[g] = 1'b0;
         tx_valid_a[g] = 1'b0; tx_data_a[g] = 16'h0000; exp_rx[g] = 16'h0000;
      end
      repeat (5) @(posedge clk);
      #1;
      for (int g = 0; g < NDUT; g++) check_reset_outs(g);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // mode 0 basic word, then the same stimulus in modes 1..3
      for (int m = 0; m < 4; m++) begin
         random_words(m);
         m_tx[0] = 16'h0003;
         f_tx[0] = 16'hF1F1;
         run_frame(m, 1, 0, 0);
      end
      // three back-to-back words with a refilled shadow
      for (int m = 0; m < 4; m += 3) begin
         random_words(m);
         f_tx[0] = 16'h1111; f_tx[1] = 16'h2222; f_tx[2] = 16'h3333;
         run_frame(m, 3, 0, 0);
      end
      // empty shadow throughout the frame
      random_words(0);
      run_frame(0, 1, 0, 4);
      random_words(1);
      run_frame(1, 1, 0, 4);
      // abort after 7 bits, then a clean frame
      random_words(0);
      run_frame(0, 0, 7, 0);
      random_words(0);
      run_frame(0, 1, 0, 0);

      // reset in the middle of a word on the 8-bit LSB-first instance
      a0 = abort_cnt[4];
      cs_a[4] = 1'b0;
      half_period();
      for (int b = 0; b < 3; b++) begin
         mosi_a[4] = b[0];
         half_period();
         sclk_a[4] = 1'b1;
         half_period();
         sclk_a[4] = 1'b0;
      end
      reset = 1'b1;
      cs_a[4] = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outs(4);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int g = 0; g < NDUT; g++) exp_rx[g] = 16'h0000;
      repeat (10) @(posedge clk);
      #1;
      check_val("rst_no_abort", 32'(abort_cnt[4] - a0), 32'd0);
      random_words(4);
      m_tx[0] = 16'h00A5;
      run_frame(4, 1, 0, 0);

      // randomized frames over all instances
      for (int it = 0; it < 16; it++) begin
         s     = $urandom_range(0, NDUT - 1);
         w     = w_of(s);
         nfull = $urandom_range(1, 3);
         part  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w - 1) : 0;
         random_words(s);
         run_frame(s, nfull, part, $urandom_range(0, 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
